// File: rtl/pio_param_pkg.sv
// Purpose : shared types and constants for the PIO parameter Avalon-MM master.
// Contents: command opcode enum, PIO register offsets, response error codes,
//           FSM state enum and the readback verify helper.
// Optional: PIO_PARAM_VERIFY_EN adds the verify-read states and compare helper.
package pio_param_pkg;

    localparam int unsigned OFS_W = 3;

    typedef enum logic [1:0] {
        OP_WRITE = 2'd0,
        OP_SET   = 2'd1,
        OP_CLEAR = 2'd2,
        OP_READ  = 2'd3
    } op_e;

    // PIO register word offsets
    localparam logic [OFS_W-1:0] OFS_DATA = 3'd0;
    localparam logic [OFS_W-1:0] OFS_SET  = 3'd4;
    localparam logic [OFS_W-1:0] OFS_CLR  = 3'd5;

    typedef enum logic [1:0] {
        ERR_OK      = 2'd0,
        ERR_TIMEOUT = 2'd1,
        ERR_VERIFY  = 2'd2
    } err_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WRITE  = 3'd1,
        ST_READ   = 3'd2,
        ST_RDWAIT = 3'd3,
        ST_RESP   = 3'd4
`ifdef PIO_PARAM_VERIFY_EN
        ,
        ST_VREAD  = 3'd5,
        ST_VWAIT  = 3'd6
`endif
    } state_e;

    // Register offset targeted by each opcode
    function automatic logic [OFS_W-1:0] op_offset(input op_e op);
        case (op)
            OP_SET:   return OFS_SET;
            OP_CLEAR: return OFS_CLR;
            default:  return OFS_DATA;
        endcase
    endfunction

`ifdef PIO_PARAM_VERIFY_EN
    // Readback check; rd and m arrive already masked to the PIO width
    function automatic logic verify_ok(input op_e op, input logic [31:0] rd,
                                       input logic [31:0] m);
        case (op)
            OP_WRITE: return rd == m;
            OP_SET:   return (rd & m) == m;
            OP_CLEAR: return (rd & m) == 32'd0;
            default:  return 1'b1;
        endcase
    endfunction
`endif

endpackage

// File: rtl/pio_param_timeout.sv
// Purpose : per-state wait counter. Cleared by load, counts while en is high,
//           expire_c flags the TIMEOUT_CYC-th consecutive enabled cycle.
// Ports   : clk, reset_n (sync, active-low), load, en -> expire_c (combinational).
module pio_param_timeout #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    input  logic en,
    output logic expire_c
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Counter value for the next cycle; holds once at the last value
    always_comb begin
        cnt_d    = cnt_q;
        expire_c = en && (cnt_q == CNT_LAST);
        if (load) begin
            cnt_d = '0;
        end else if (en && !expire_c) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pio_param_avmm_master.sv
// Purpose : Avalon-MM master driving the parameter/reset PIO slaves from local
//           control logic. One command at a time (WRITE/SET/CLEAR/READ), one-cycle
//           response strobe, per-phase timeout protection.
// Ports   : clk, reset_n (sync, active-low)
//           cmd_valid/cmd_ready/cmd_op/cmd_base/cmd_wdata   command side
//           rsp_valid/rsp_rdata/rsp_error, busy             response side
//           avm_*                                           Avalon-MM master
// Optional: PIO_PARAM_VERIFY_EN adds a readback of offset 0 after every write-type
//           command, compared against the command mask.
module pio_param_avmm_master
    import pio_param_pkg::*;
#(
    parameter int unsigned BASE_W      = 4,
    parameter int unsigned DATA_W      = 1,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [BASE_W-1:0] cmd_base,
    input  logic [31:0]       cmd_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic [1:0]        rsp_error,
    output logic              busy,
    output logic [BASE_W+2:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    input  logic              avm_waitrequest,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_readdatavalid
);

    localparam int unsigned ADDR_W = BASE_W + OFS_W;
    localparam logic [31:0] DATA_MASK =
        (DATA_W >= 32) ? 32'hFFFF_FFFF : 32'((64'd1 << DATA_W) - 64'd1);

    state_e state_q, state_d;

    op_e               op_q, op_d;
    logic [BASE_W-1:0] base_q, base_d;
    logic [31:0]       wdata_q, wdata_d;

    logic              cmd_ready_q, cmd_ready_d;
    logic              busy_q, busy_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    err_e              rsp_error_q, rsp_error_d;
    logic              avm_read_q, avm_read_d;
    logic              avm_write_q, avm_write_d;
    logic [ADDR_W-1:0] avm_address_q, avm_address_d;
    logic [31:0]       avm_writedata_q, avm_writedata_d;

    logic is_rd_req;
    logic is_rd_wait;
    logic data_hit;
    logic tmo_load;
    logic tmo_en;
    logic tmo_expire_c;
`ifdef PIO_PARAM_VERIFY_EN
    logic is_vfy;
`endif

    // State decode shared by the primary read and the verify read
    always_comb begin
        is_rd_req  = (state_q == ST_READ);
        is_rd_wait = (state_q == ST_RDWAIT);
`ifdef PIO_PARAM_VERIFY_EN
        is_rd_req  = is_rd_req  || (state_q == ST_VREAD);
        is_rd_wait = is_rd_wait || (state_q == ST_VWAIT);
        is_vfy     = (state_q == ST_VREAD) || (state_q == ST_VWAIT);
`endif
        // Zero-latency slaves return data in the same cycle the read is accepted
        data_hit = avm_readdatavalid && (is_rd_wait || (is_rd_req && !avm_waitrequest));
        tmo_en   = (state_q == ST_WRITE) || is_rd_req || is_rd_wait;
        tmo_load = (state_d != state_q);
    end

    pio_param_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (tmo_load),
        .en       (tmo_en),
        .expire_c (tmo_expire_c)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a handshake completing in the expiry cycle wins over timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_d = (op_e'(cmd_op) == OP_READ) ? ST_READ : ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (!avm_waitrequest) begin
`ifdef PIO_PARAM_VERIFY_EN
                    state_d = ST_VREAD;
`else
                    state_d = ST_RESP;
`endif
                end else if (tmo_expire_c) begin
                    state_d = ST_RESP;
                end
            end
            ST_READ: begin
                if (!avm_waitrequest) begin
                    state_d = avm_readdatavalid ? ST_RESP : ST_RDWAIT;
                end else if (tmo_expire_c) begin
                    state_d = ST_RESP;
                end
            end
            ST_RDWAIT: begin
                if (avm_readdatavalid || tmo_expire_c) begin
                    state_d = ST_RESP;
                end
            end
`ifdef PIO_PARAM_VERIFY_EN
            ST_VREAD: begin
                if (!avm_waitrequest) begin
                    state_d = avm_readdatavalid ? ST_RESP : ST_VWAIT;
                end else if (tmo_expire_c) begin
                    state_d = ST_RESP;
                end
            end
            ST_VWAIT: begin
                if (avm_readdatavalid || tmo_expire_c) begin
                    state_d = ST_RESP;
                end
            end
`endif
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic: registered outputs follow the next state
    always_comb begin
        op_d    = op_q;
        base_d  = base_q;
        wdata_d = wdata_q;
        if ((state_q == ST_IDLE) && cmd_valid) begin
            op_d    = op_e'(cmd_op);
            base_d  = cmd_base;
            wdata_d = cmd_wdata;
        end

        cmd_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
        avm_write_d = (state_d == ST_WRITE);
        avm_read_d  = (state_d == ST_READ);
`ifdef PIO_PARAM_VERIFY_EN
        avm_read_d  = avm_read_d || (state_d == ST_VREAD);
`endif

        avm_address_d   = '0;
        avm_writedata_d = '0;
        if (avm_write_d) begin
            avm_address_d   = {base_d, op_offset(op_d)};
            avm_writedata_d = wdata_d;
        end else if (avm_read_d) begin
            avm_address_d = {base_d, OFS_DATA};
        end

        // Response payload is only meaningful in the RESP cycle
        rsp_valid_d = (state_d == ST_RESP);
        rsp_rdata_d = '0;
        rsp_error_d = ERR_OK;
        if (state_d == ST_RESP) begin
            if (data_hit) begin
                rsp_rdata_d = avm_readdata & DATA_MASK;
`ifdef PIO_PARAM_VERIFY_EN
                if (is_vfy && !verify_ok(op_q, avm_readdata & DATA_MASK,
                                         wdata_q & DATA_MASK)) begin
                    rsp_error_d = ERR_VERIFY;
                end
`endif
            end else if (!((state_q == ST_WRITE) && !avm_waitrequest)) begin
                rsp_error_d = ERR_TIMEOUT;
            end
        end
    end

    // Command latch and output registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            op_q            <= OP_WRITE;
            base_q          <= '0;
            wdata_q         <= '0;
            cmd_ready_q     <= 1'b1;
            busy_q          <= 1'b0;
            rsp_valid_q     <= 1'b0;
            rsp_rdata_q     <= '0;
            rsp_error_q     <= ERR_OK;
            avm_read_q      <= 1'b0;
            avm_write_q     <= 1'b0;
            avm_address_q   <= '0;
            avm_writedata_q <= '0;
        end else begin
            op_q            <= op_d;
            base_q          <= base_d;
            wdata_q         <= wdata_d;
            cmd_ready_q     <= cmd_ready_d;
            busy_q          <= busy_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_rdata_q     <= rsp_rdata_d;
            rsp_error_q     <= rsp_error_d;
            avm_read_q      <= avm_read_d;
            avm_write_q     <= avm_write_d;
            avm_address_q   <= avm_address_d;
            avm_writedata_q <= avm_writedata_d;
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign busy          = busy_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_error     = rsp_error_q;
    assign avm_read      = avm_read_q;
    assign avm_write     = avm_write_q;
    assign avm_address   = avm_address_q;
    assign avm_writedata = avm_writedata_q;

endmodule

// File: tb/tb_pio_param_avmm_master.sv
// Bench for pio_param_avmm_master: directed and random commands against a reactive
// Avalon slave; expected latency, error and data come from a cycle-count model.
module tb_pio_param_avmm_master;

    localparam int unsigned BASE_W = 4;
    localparam int unsigned DATA_W = 1;
    localparam int          T      = 8;
    localparam int          WIN    = 36;
    localparam logic [31:0] DMASK  = 32'h0000_0001;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [BASE_W-1:0] cmd_base;
    logic [31:0]       cmd_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic [1:0]        rsp_error;
    logic              busy;
    logic [BASE_W+2:0] avm_address;
    logic              avm_read;
    logic              avm_write;
    logic [31:0]       avm_writedata;
    logic              avm_waitrequest;
    logic [31:0]       avm_readdata;
    logic              avm_readdatavalid;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pio_param_avmm_master #(
        .BASE_W      (BASE_W),
        .DATA_W      (DATA_W),
        .TIMEOUT_CYC (T)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_op            (cmd_op),
        .cmd_base          (cmd_base),
        .cmd_wdata         (cmd_wdata),
        .rsp_valid         (rsp_valid),
        .rsp_rdata         (rsp_rdata),
        .rsp_error         (rsp_error),
        .busy              (busy),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_write         (avm_write),
        .avm_writedata     (avm_writedata),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One bus read phase starting at cycle s: resp cycle, success flag, strobe cycles
    task automatic read_phase(input int s, input int rs, input int rl,
                              output int resp, output bit ok, output int ncyc);
        int a;
        ncyc = (rs >= T) ? T : rs + 1;
        if (rs >= T) begin
            resp = s + T;
            ok   = 1'b0;
        end else begin
            a = s + rs;
            if (rl <= T) begin
                resp = a + 1 + rl;
                ok   = 1'b1;
            end else begin
                resp = a + 1 + T;
                ok   = 1'b0;
            end
        end
    endtask

    // Expected outcome of a command, cycle 0 being the accept cycle
    task automatic model(input int op, input int ws, input int rs, input int rl,
                         input logic [31:0] wdata, input logic [31:0] rdata,
                         output int rcyc, output int err, output logic [31:0] rd,
                         output int wcyc, output int rdcyc);
        bit ok;
        logic [31:0] m;
        bit pass;
        wcyc  = 0;
        rdcyc = 0;
        err   = 0;
        rd    = 32'd0;
        rcyc  = 0;
        m     = wdata & DMASK;
        pass  = 1'b1;
        if (op == 3) begin
            read_phase(1, rs, rl, rcyc, ok, rdcyc);
            if (ok) rd = rdata & DMASK;
            else err = 1;
        end else begin
            wcyc = (ws >= T) ? T : ws + 1;
            if (ws >= T) begin
                rcyc = 1 + T;
                err  = 1;
            end else begin
`ifdef PIO_PARAM_VERIFY_EN
                read_phase(ws + 2, rs, rl, rcyc, ok, rdcyc);
                if (!ok) begin
                    err = 1;
                end else begin
                    rd = rdata & DMASK;
                    case (op)
                        0:       pass = (rd == m);
                        1:       pass = ((rd & m) == m);
                        default: pass = ((rd & m) == 32'd0);
                    endcase
                    err = pass ? 0 : 2;
                end
`else
                rcyc = ws + 2;
`endif
            end
        end
    endtask

    // Issue one command and play the slave for a fixed window of cycles
    task automatic run_cmd(input int op, input logic [BASE_W-1:0] base, input logic [31:0] wdata,
                           input int ws, input int rs, input int rl, input logic [31:0] rdata);
        int exp_cyc, exp_err, exp_wc, exp_rc;
        logic [31:0] exp_rd;
        int nrsp, rsp_at, wc, rc, wcnt, rcnt, rdv_in, bad_addr, overlap, bad_ready;
        logic [1:0] got_err;
        logic [31:0] got_rd;
        logic [2:0] ofs;
        logic [BASE_W+2:0] waddr, raddr;
        model(op, ws, rs, rl, wdata, rdata, exp_cyc, exp_err, exp_rd, exp_wc, exp_rc);
        case (op)
            1:       ofs = 3'd4;
            2:       ofs = 3'd5;
            default: ofs = 3'd0;
        endcase
        waddr = {base, ofs};
        raddr = {base, 3'd0};
        nrsp = 0; rsp_at = -1; wc = 0; rc = 0; wcnt = 0; rcnt = 0; rdv_in = -1;
        bad_addr = 0; overlap = 0; bad_ready = 0; got_err = 2'd0; got_rd = 32'd0;

        check("ready_before_cmd", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = 2'(op);
        cmd_base  = base;
        cmd_wdata = wdata;
        for (int k = 1; k <= WIN; k++) begin
            @(negedge clk);
            if (avm_write && avm_read) overlap++;
            if (avm_write) begin
                wc++;
                if (avm_address !== waddr || avm_writedata !== wdata) bad_addr++;
            end
            if (avm_read) begin
                rc++;
                if (avm_address !== raddr) bad_addr++;
            end
            if (rsp_at < 0 && (cmd_ready !== 1'b0 || busy !== 1'b1)) bad_ready++;
            if (rsp_valid) begin
                nrsp++;
                if (rsp_at < 0) begin
                    rsp_at  = k;
                    got_err = rsp_error;
                    got_rd  = rsp_rdata;
                end
            end
            // slave response for the coming edge
            avm_readdatavalid = 1'b0;
            avm_readdata      = $urandom;
            if (rdv_in > 0) begin
                rdv_in--;
                if (rdv_in == 0) begin
                    avm_readdatavalid = 1'b1;
                    avm_readdata      = rdata;
                end
            end
            avm_waitrequest = 1'($urandom_range(0, 1));
            if (avm_write) begin
                avm_waitrequest = (wcnt < ws);
                wcnt++;
            end else if (avm_read) begin
                avm_waitrequest = (rcnt < rs);
                rcnt++;
                if (!avm_waitrequest) begin
                    if (rl == 0) begin
                        avm_readdatavalid = 1'b1;
                        avm_readdata      = rdata;
                    end else begin
                        rdv_in = rl;
                    end
                end
            end
            // commands while busy must be ignored; stop offering once the response is seen
            cmd_valid = (rsp_at < 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            cmd_op    = 2'($urandom_range(0, 3));
            cmd_base  = BASE_W'($urandom);
            cmd_wdata = $urandom;
        end
        avm_readdatavalid = 1'b0;
        avm_waitrequest   = 1'b0;

        check("rsp_count", 32'(nrsp), 32'd1);
        check("rsp_cycle", 32'(rsp_at), 32'(exp_cyc));
        check("rsp_error", 32'(got_err), 32'(exp_err));
        check("rsp_rdata", got_rd, exp_rd);
        check("write_strobe_cycles", 32'(wc), 32'(exp_wc));
        check("read_strobe_cycles", 32'(rc), 32'(exp_rc));
        check("addr_data_stable", 32'(bad_addr), 32'd0);
        check("rd_wr_overlap", 32'(overlap), 32'd0);
        check("busy_ready_while_active", 32'(bad_ready), 32'd0);
    endtask

    int n_rsp;

    initial begin
        reset_n           = 1'b0;
        cmd_valid         = 1'b0;
        cmd_op            = 2'd0;
        cmd_base          = '0;
        cmd_wdata         = 32'd0;
        avm_waitrequest   = 1'b0;
        avm_readdata      = 32'd0;
        avm_readdatavalid = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_error", 32'(rsp_error), 32'd0);
        check("rst_avm_read", 32'(avm_read), 32'd0);
        check("rst_avm_write", 32'(avm_write), 32'd0);
        check("rst_avm_address", 32'(avm_address), 32'd0);
        check("rst_avm_writedata", avm_writedata, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // WRITE base 2 data 1, no stall: address 0x10
        run_cmd(0, 4'd2, 32'd1, 0, 0, 0, 32'd1);
        // SET with a 3-cycle stall: write held 4 cycles at base|4
        run_cmd(1, 4'd5, 32'd1, 3, 0, 0, 32'd1);
        // READ, data one cycle after acceptance, only bit 0 returned
        run_cmd(3, 4'd3, 32'd0, 0, 0, 1, 32'hFFFF_FFFF);
        // READ, zero-latency slave
        run_cmd(3, 4'd9, 32'd0, 2, 0, 0, 32'h0000_0001);
        // READ, data never inside the window: timeout, late valid ignored
        run_cmd(3, 4'd1, 32'd0, 0, 0, T + 3, 32'h1);
        // READ, waitrequest stuck high
        run_cmd(3, 4'd7, 32'd0, 0, T + 1, 0, 32'h1);
        // WRITE, waitrequest stuck high
        run_cmd(0, 4'd4, 32'd1, T + 2, 0, 0, 32'h1);
        // CLEAR with readback 1 then 0
        run_cmd(2, 4'd6, 32'd1, 0, 0, 0, 32'h1);
        run_cmd(2, 4'd6, 32'd1, 1, 1, 2, 32'h0);

        for (int i = 0; i < 30; i++) begin
            int op, ws, rs, rl;
            op = int'($urandom_range(0, 3));
            ws = ($urandom_range(0, 5) == 0) ? int'($urandom_range(T, T + 2)) : int'($urandom_range(0, T - 1));
            rs = ($urandom_range(0, 5) == 0) ? int'($urandom_range(T, T + 2)) : int'($urandom_range(0, T - 1));
            rl = int'($urandom_range(0, T + 3));
            run_cmd(op, BASE_W'($urandom), $urandom, ws, rs, rl, $urandom);
        end

        // Reset in the middle of a stalled write
        check("ready_before_abort", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = 2'd1;
        cmd_base  = 4'd3;
        cmd_wdata = 32'd1;
        @(negedge clk);
        cmd_valid       = 1'b0;
        avm_waitrequest = 1'b1;
        check("abort_write_active", 32'(avm_write), 32'd1);
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check("abort_avm_write", 32'(avm_write), 32'd0);
        check("abort_avm_read", 32'(avm_read), 32'd0);
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        check("abort_cmd_ready", 32'(cmd_ready), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        reset_n         = 1'b1;
        avm_waitrequest = 1'b0;
        n_rsp = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (rsp_valid || avm_write || avm_read) n_rsp++;
        end
        check("abort_no_activity", 32'(n_rsp), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
